game_sequencer: RTL and testbench

Frame-synchronous game controller for the quidditch display. It watches the same pixel counters the display renderer uses and advances the game once per frame. Each frame it moves both players from the buttons, steps and bounces the ball, detects scoring and runs the serve/score/game-over sequence. Its position outputs drive the renderer's player and ball coordinate inputs directly.

---
 rtl/game_pkg.sv | 24 ++
 rtl/game_sequencer_paddle_ctrl.sv | 50 +++++
 rtl/game_sequencer.sv | 239 +++++++++++++++++++++++
 tb/tb_game_sequencer.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared definitions for the quidditch game controller: state encoding and
// field geometry in renderer pixel coordinates.
package game_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PLAY  = 2'd1,
        ST_SCORE = 2'd2,
        ST_OVER  = 2'd3
    } game_state_t;

    localparam int H_ACT_MIN = 144;
    localparam int H_ACT_MAX = 783;
    localparam int V_ACT_MIN = 35;
    localparam int V_ACT_MAX = 514;

    localparam int PLAYER1_X = 300;
    localparam int PLAYER2_X = 600;
    localparam int CENTER_X  = 463;
    localparam int CENTER_Y  = 275;

    localparam logic [9:0] PLAYER_RST_POS = 10'd275;

endpackage

// File: rtl/game_sequencer_paddle_ctrl.sv
// Player position register: moves by a fixed step per frame while one button
// is held and clamps the disc so it stays fully inside the field.
module paddle_ctrl
    import game_pkg::*;
#(
    parameter int PLAYER_RADIUS = 25,
    parameter int PLAYER_SPEED  = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick,
    input  logic       en,
    input  logic       up,
    input  logic       dn,
    output logic [9:0] pos
);

    localparam logic signed [10:0] POS_MIN = 11'(V_ACT_MIN + PLAYER_RADIUS);
    localparam logic signed [10:0] POS_MAX = 11'(V_ACT_MAX - PLAYER_RADIUS);
    localparam logic signed [10:0] STEP    = 11'(PLAYER_SPEED);

    function automatic logic [9:0] clamp_pos(input logic signed [10:0] v);
        if (v < POS_MIN)
            return POS_MIN[9:0];
        else if (v > POS_MAX)
            return POS_MAX[9:0];
        else
            return v[9:0];
    endfunction

    logic signed [10:0] pos_s;
    logic signed [10:0] pos_nxt;

    always_comb begin
        pos_s   = $signed({1'b0, pos});
        pos_nxt = pos_s;
        if (up && !dn)
            pos_nxt = pos_s - STEP;
        else if (dn && !up)
            pos_nxt = pos_s + STEP;
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            pos <= PLAYER_RST_POS;
        else if (tick && en)
            pos <= clamp_pos(pos_nxt);
    end

endmodule

// File: rtl/game_sequencer.sv
// Frame-synchronous quidditch controller: one game update per display frame,
// covering player motion, ball stepping and bouncing, goals and match flow.
module game_sequencer
    import game_pkg::*;
#(
    parameter int PLAYER_RADIUS     = 25,
    parameter int BALL_RADIUS       = 5,
    parameter int PLAYER_SPEED      = 4,
    parameter int BALL_SPEED        = 2,
    parameter int SCORE_HOLD_FRAMES = 60,
    parameter int WIN_SCORE         = 7
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [9:0] x,
    input  logic [9:0] y,
    input  logic       btn_t1_up,
    input  logic       btn_t1_dn,
    input  logic       btn_t2_up,
    input  logic       btn_t2_dn,
    input  logic       btn_start,
    output logic [9:0] team1_ver_pos,
    output logic [9:0] team2_ver_pos,
    output logic [9:0] ball_x,
    output logic [9:0] ball_y,
    output logic [3:0] score1,
    output logic [3:0] score2,
    output logic [1:0] game_state,
    output logic       frame_tick
);

    localparam logic signed [10:0] Y_MIN  = 11'(V_ACT_MIN + BALL_RADIUS);
    localparam logic signed [10:0] Y_MAX  = 11'(V_ACT_MAX - BALL_RADIUS);
    localparam logic signed [10:0] X_MIN  = 11'(H_ACT_MIN + BALL_RADIUS);
    localparam logic signed [10:0] X_MAX  = 11'(H_ACT_MAX - BALL_RADIUS);
    localparam logic signed [10:0] HIT1_X = 11'(PLAYER1_X + PLAYER_RADIUS + BALL_RADIUS);
    localparam logic signed [10:0] HIT2_X = 11'(PLAYER2_X - PLAYER_RADIUS - BALL_RADIUS);
    localparam logic signed [10:0] REACH  = 11'(PLAYER_RADIUS + BALL_RADIUS);
    localparam logic signed [10:0] STEP   = 11'(BALL_SPEED);
    localparam logic [9:0]         CX     = 10'(CENTER_X);
    localparam logic [9:0]         CY     = 10'(CENTER_Y);
    localparam logic [7:0]         HOLD   = 8'(SCORE_HOLD_FRAMES);
    localparam logic [3:0]         WIN    = 4'(WIN_SCORE);

    function automatic logic [3:0] sat_inc(input logic [3:0] s);
        return (s == 4'hF) ? s : s + 4'd1;
    endfunction

    function automatic logic signed [10:0] abs11(input logic signed [10:0] v);
        return (v < 0) ? -v : v;
    endfunction

    game_state_t state, state_nxt;
    logic        origin_p0;
    logic        at_origin;
    logic        vx_pos, vx_nxt;
    logic        vy_pos, vy_nxt;
    logic        serve_pos, serve_nxt;
    logic [7:0]  hold_cnt, hold_nxt;
    logic [9:0]  bx_nxt, by_nxt;
    logic [3:0]  s1_nxt, s2_nxt;
    logic        restart;
    logic        paddle_rst_n;
    logic        paddle_en;

    logic signed [10:0] bx_s, by_s, nx, ny, t1_s, t2_s;
    logic               hit1, hit2, goal1, goal2;

    // Origin edge detect -> registered frame_tick
    assign at_origin = (x == 10'd0) && (y == 10'd0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            origin_p0  <= 1'b1;
            frame_tick <= 1'b0;
        end else begin
            origin_p0  <= at_origin;
            frame_tick <= at_origin && !origin_p0;
        end
    end

    // Players
    assign paddle_en    = (state != ST_OVER);
    assign paddle_rst_n = rst_n && !(frame_tick && restart);

    paddle_ctrl #(
        .PLAYER_RADIUS(PLAYER_RADIUS),
        .PLAYER_SPEED (PLAYER_SPEED)
    ) u_paddle1 (
        .clk  (clk),
        .rst_n(paddle_rst_n),
        .tick (frame_tick),
        .en   (paddle_en),
        .up   (btn_t1_up),
        .dn   (btn_t1_dn),
        .pos  (team1_ver_pos)
    );

    paddle_ctrl #(
        .PLAYER_RADIUS(PLAYER_RADIUS),
        .PLAYER_SPEED (PLAYER_SPEED)
    ) u_paddle2 (
        .clk  (clk),
        .rst_n(paddle_rst_n),
        .tick (frame_tick),
        .en   (paddle_en),
        .up   (btn_t2_up),
        .dn   (btn_t2_dn),
        .pos  (team2_ver_pos)
    );

    // Ball step candidates and collision tests, all from pre-tick values
    assign bx_s = $signed({1'b0, ball_x});
    assign by_s = $signed({1'b0, ball_y});
    assign t1_s = $signed({1'b0, team1_ver_pos});
    assign t2_s = $signed({1'b0, team2_ver_pos});
    assign nx   = bx_s + (vx_pos ? STEP : -STEP);
    assign ny   = by_s + (vy_pos ? STEP : -STEP);

    assign hit1  = !vx_pos && (bx_s > HIT1_X) && (nx <= HIT1_X)
                   && (abs11(by_s - t1_s) <= REACH);
    assign hit2  = vx_pos && (bx_s < HIT2_X) && (nx >= HIT2_X)
                   && (abs11(by_s - t2_s) <= REACH);
    assign goal2 = (nx <= X_MIN);
    assign goal1 = (nx >= X_MAX);

    // Next-state and next-value logic
    always_comb begin
        state_nxt = state;
        bx_nxt    = ball_x;
        by_nxt    = ball_y;
        vx_nxt    = vx_pos;
        vy_nxt    = vy_pos;
        serve_nxt = serve_pos;
        hold_nxt  = hold_cnt;
        s1_nxt    = score1;
        s2_nxt    = score2;
        restart   = 1'b0;

        case (state)
            ST_IDLE: begin
                bx_nxt = CX;
                by_nxt = CY;
                if (btn_start) begin
                    state_nxt = ST_PLAY;
                    vx_nxt    = serve_pos;
                    vy_nxt    = 1'b1;
                end
            end

            ST_PLAY: begin
                if (ny <= Y_MIN) begin
                    by_nxt = Y_MIN[9:0];
                    vy_nxt = 1'b1;
                end else if (ny >= Y_MAX) begin
                    by_nxt = Y_MAX[9:0];
                    vy_nxt = 1'b0;
                end else begin
                    by_nxt = ny[9:0];
                end

                if (hit1) begin
                    bx_nxt = HIT1_X[9:0];
                    vx_nxt = 1'b1;
                end else if (hit2) begin
                    bx_nxt = HIT2_X[9:0];
                    vx_nxt = 1'b0;
                end else if (goal2 || goal1) begin
                    // Serve next rally toward whoever conceded
                    if (goal2)
                        s2_nxt = sat_inc(score2);
                    else
                        s1_nxt = sat_inc(score1);
                    serve_nxt = goal1;
                    bx_nxt    = CX;
                    by_nxt    = CY;
                    hold_nxt  = HOLD;
                    state_nxt = ST_SCORE;
                end else begin
                    bx_nxt = nx[9:0];
                end
            end

            ST_SCORE: begin
                if (hold_cnt <= 8'd1) begin
                    hold_nxt = 8'd0;
                    if ((score1 >= WIN) || (score2 >= WIN)) begin
                        state_nxt = ST_OVER;
                    end else begin
                        state_nxt = ST_PLAY;
                        vx_nxt    = serve_pos;
                        vy_nxt    = 1'b1;
                    end
                end else begin
                    hold_nxt = hold_cnt - 8'd1;
                end
            end

            ST_OVER: begin
                if (btn_start) begin
                    s1_nxt    = 4'd0;
                    s2_nxt    = 4'd0;
                    restart   = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end

            default: state_nxt = ST_IDLE;
        endcase
    end

    // Game registers, updated once per frame
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            ball_x    <= CX;
            ball_y    <= CY;
            vx_pos    <= 1'b1;
            vy_pos    <= 1'b1;
            serve_pos <= 1'b1;
            hold_cnt  <= 8'd0;
            score1    <= 4'd0;
            score2    <= 4'd0;
        end else if (frame_tick) begin
            state     <= state_nxt;
            ball_x    <= bx_nxt;
            ball_y    <= by_nxt;
            vx_pos    <= vx_nxt;
            vy_pos    <= vy_nxt;
            serve_pos <= serve_nxt;
            hold_cnt  <= hold_nxt;
            score1    <= s1_nxt;
            score2    <= s2_nxt;
        end
    end

    assign game_state = state;

endmodule

// File: tb/tb_game_sequencer.sv
// Bench for game_sequencer: player-button vector table, frame-tick corner
// sequences, and long randomized games against a rule-level game model.
module tb_game_sequencer;

    localparam int PR = 25, BR = 5, PS = 4, BS = 2, HOLD = 60, WINS = 7;
    localparam int P_LO = 35 + PR, P_HI = 514 - PR;
    localparam int B_YLO = 35 + BR, B_YHI = 514 - BR;
    localparam int B_XLO = 144 + BR, B_XHI = 783 - BR;
    localparam int HIT_L = 300 + PR + BR, HIT_R = 600 - PR - BR;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [9:0] x = 10'd5, y = 10'd5;
    logic       t1u = 0, t1d = 0, t2u = 0, t2d = 0, start = 0;
    logic [9:0] team1_ver_pos, team2_ver_pos, ball_x, ball_y;
    logic [3:0] score1, score2;
    logic [1:0] game_state;
    logic       frame_tick;

    int checks = 0;
    int errors = 0;
    int tick_seen = 0;

    // Rule-level model state
    int m_t1, m_t2, m_bx, m_by, m_vx, m_vy, m_serve, m_st, m_s1, m_s2, m_frozen;

    game_sequencer dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .x            (x),
        .y            (y),
        .btn_t1_up    (t1u),
        .btn_t1_dn    (t1d),
        .btn_t2_up    (t2u),
        .btn_t2_dn    (t2d),
        .btn_start    (start),
        .team1_ver_pos(team1_ver_pos),
        .team2_ver_pos(team2_ver_pos),
        .ball_x       (ball_x),
        .ball_y       (ball_y),
        .score1       (score1),
        .score2       (score2),
        .game_state   (game_state),
        .frame_tick   (frame_tick)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (frame_tick) tick_seen++;

    typedef struct {
        bit u1, d1, u2, d2;
        int n;
        int exp_t1, exp_t2;
    } vec_t;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    function automatic int pmove(input int p, input bit u, input bit d);
        int n;
        n = p + (d ? PS : 0) - (u ? PS : 0);
        if (n < P_LO) n = P_LO;
        if (n > P_HI) n = P_HI;
        return n;
    endfunction

    task automatic m_reset();
        m_t1 = 275; m_t2 = 275; m_bx = 463; m_by = 275;
        m_vx = 1; m_vy = 1; m_serve = 1; m_st = 0;
        m_s1 = 0; m_s2 = 0; m_frozen = 0;
    endtask

    task automatic model_tick(input bit u1, d1, u2, d2, st);
        int o_t1, o_t2, o_bx, o_by, nx, ny;
        o_t1 = m_t1; o_t2 = m_t2; o_bx = m_bx; o_by = m_by;
        if (m_st != 3) begin
            m_t1 = pmove(o_t1, u1, d1);
            m_t2 = pmove(o_t2, u2, d2);
        end
        case (m_st)
            0: if (st) begin m_st = 1; m_vx = m_serve; m_vy = 1; end
            1: begin
                nx = o_bx + m_vx * BS;
                ny = o_by + m_vy * BS;
                if (ny <= B_YLO) begin ny = B_YLO; m_vy = 1; end
                else if (ny >= B_YHI) begin ny = B_YHI; m_vy = -1; end
                m_by = ny;
                if (m_vx < 0 && o_bx > HIT_L && nx <= HIT_L && iabs(o_by - o_t1) <= PR + BR) begin
                    m_bx = HIT_L; m_vx = 1;
                end else if (m_vx > 0 && o_bx < HIT_R && nx >= HIT_R && iabs(o_by - o_t2) <= PR + BR) begin
                    m_bx = HIT_R; m_vx = -1;
                end else if (nx <= B_XLO || nx >= B_XHI) begin
                    if (nx <= B_XLO) begin m_s2 = (m_s2 < 15) ? m_s2 + 1 : 15; m_serve = -1; end
                    else begin m_s1 = (m_s1 < 15) ? m_s1 + 1 : 15; m_serve = 1; end
                    m_bx = 463; m_by = 275; m_st = 2; m_frozen = 0;
                end else begin
                    m_bx = nx;
                end
            end
            2: begin
                m_frozen++;
                if (m_frozen == HOLD) begin
                    if (m_s1 >= WINS || m_s2 >= WINS) m_st = 3;
                    else begin m_st = 1; m_vx = m_serve; m_vy = 1; end
                end
            end
            default: if (st) begin
                m_s1 = 0; m_s2 = 0; m_t1 = 275; m_t2 = 275; m_st = 0;
            end
        endcase
    endtask

    task automatic compare_all(input string tag);
        check({tag, "_t1"}, int'(team1_ver_pos), m_t1);
        check({tag, "_t2"}, int'(team2_ver_pos), m_t2);
        check({tag, "_bx"}, int'(ball_x), m_bx);
        check({tag, "_by"}, int'(ball_y), m_by);
        check({tag, "_s1"}, int'(score1), m_s1);
        check({tag, "_s2"}, int'(score2), m_s2);
        check({tag, "_state"}, int'(game_state), m_st);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_t1"}, int'(team1_ver_pos), 275);
        check({tag, "_t2"}, int'(team2_ver_pos), 275);
        check({tag, "_bx"}, int'(ball_x), 463);
        check({tag, "_by"}, int'(ball_y), 275);
        check({tag, "_s1"}, int'(score1), 0);
        check({tag, "_s2"}, int'(score2), 0);
        check({tag, "_state"}, int'(game_state), 0);
        check({tag, "_tick"}, int'(frame_tick), 0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        x = 10'd5; y = 10'd5;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        m_reset();
    endtask

    // One frame: origin for one clk, then the tick cycle, then settled outputs
    task automatic do_tick();
        @(negedge clk); x = 10'd0; y = 10'd0;
        @(negedge clk); x = 10'd1;
        check("tick_high", int'(frame_tick), 1);
        @(negedge clk);
        check("tick_low", int'(frame_tick), 0);
        model_tick(t1u, t1d, t2u, t2d, start);
    endtask

    vec_t vecs[6];

    initial begin
        vecs[0] = '{0, 0, 0, 0,   3, 275, 275};
        vecs[1] = '{1, 0, 1, 1,  60,  60, 275};
        vecs[2] = '{0, 1, 0, 1,  10, 100, 315};
        vecs[3] = '{0, 1, 1, 0, 120, 489,  60};
        vecs[4] = '{1, 1, 0, 1,   5, 489,  80};
        vecs[5] = '{1, 0, 0, 0,   2, 481,  80};

        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_vals("reset");
        rst_n = 1'b1;
        m_reset();

        // Counters parked at the origin for three clocks give one tick
        @(negedge clk); tick_seen = 0; x = 10'd0; y = 10'd0;
        repeat (3) @(negedge clk);
        x = 10'd1;
        repeat (2) @(negedge clk);
        check("held_origin_ticks", tick_seen, 1);
        model_tick(0, 0, 0, 0, 0);
        compare_all("idle");

        // Reset released while at the origin must not tick
        x = 10'd0; y = 10'd0; rst_n = 1'b0;
        repeat (2) @(negedge clk);
        tick_seen = 0;
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        x = 10'd1;
        repeat (2) @(negedge clk);
        check("reset_at_origin_ticks", tick_seen, 0);
        m_reset();

        // Player movement table
        for (int v = 0; v < 6; v++) begin
            t1u = vecs[v].u1; t1d = vecs[v].d1; t2u = vecs[v].u2; t2d = vecs[v].d2;
            for (int k = 0; k < vecs[v].n; k++) begin
                do_tick();
                compare_all("tbl");
            end
            check("tbl_end_t1", int'(team1_ver_pos), vecs[v].exp_t1);
            check("tbl_end_t2", int'(team2_ver_pos), vecs[v].exp_t2);
        end
        t1u = 0; t1d = 0; t2u = 0; t2d = 0;

        // Randomized games with serve/restart presses
        do_reset();
        for (int i = 0; i < 4500 && errors < 40; i++) begin
            t1u = 1'($urandom_range(0, 1)); t1d = 1'($urandom_range(0, 1));
            t2u = 1'($urandom_range(0, 1)); t2d = 1'($urandom_range(0, 1));
            start = ($urandom_range(0, 7) == 0);
            do_tick();
            compare_all("rnd");
        end
        start = 0;

        // Reset asserted during a tick cycle mid-PLAY overrides the update
        do_reset();
        start = 1'b1;
        do_tick();
        start = 1'b0; t1u = 1'b1; t2d = 1'b1;
        repeat (15) begin
            do_tick();
            compare_all("pre_rst");
        end
        check("pre_rst_play", int'(game_state), 1);
        @(negedge clk); x = 10'd0; y = 10'd0;
        @(negedge clk); x = 10'd1; rst_n = 1'b0;
        check("rst_tick_high", int'(frame_tick), 1);
        @(negedge clk); rst_n = 1'b1;
        check_reset_vals("mid_rst");
        t1u = 0; t2d = 0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
